// File: rtl/gpp_regctl_pkg.sv
// Shared encodings for the GPP register-file access sequencer: command fields,
// FSM state codes and the command payload struct.
package gpp_regctl_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ST_W  = 3;

    localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
    localparam logic [OP_W-1:0] OP_READ = 2'b01;
    localparam logic [OP_W-1:0] OP_ALU  = 2'b10;

    localparam logic [SEL_W-1:0] SEL_X    = 2'b00;
    localparam logic [SEL_W-1:0] SEL_Y    = 2'b01;
    localparam logic [SEL_W-1:0] SEL_ACC  = 2'b10;
    localparam logic [SEL_W-1:0] SEL_RSVD = 2'b11;

    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_WAIT_MEM = 3'd1;
    localparam logic [ST_W-1:0] ST_WRITE    = 3'd2;
    localparam logic [ST_W-1:0] ST_READ     = 3'd3;
    localparam logic [ST_W-1:0] ST_OPND     = 3'd4;
    localparam logic [ST_W-1:0] ST_WAIT_ALU = 3'd5;
    localparam logic [ST_W-1:0] ST_SAVE     = 3'd6;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [SEL_W-1:0] sel;
    } regctl_cmd_t;

    // ACC is only a legal target for LOAD; anything else is accepted and dropped.
    function automatic logic cmd_is_legal(input regctl_cmd_t cmd);
        logic legal;
        legal = 1'b0;
        case (cmd.op)
            OP_LOAD:         legal = (cmd.sel != SEL_RSVD);
            OP_READ, OP_ALU: legal = (cmd.sel == SEL_X) || (cmd.sel == SEL_Y);
            default:         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/regctl_timeout_ctr.sv
// Wait-state cycle counter; flags the last permitted wait cycle.
module regctl_timeout_ctr #(
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired_c = (r_count == CNT_W'(WAIT_TIMEOUT - 1));

endmodule

// File: rtl/regfile_access_sequencer.sv
// Expands LOAD/READ/ALU register commands into register-file strobes, waiting
// on memory data or ALU completion with a bounded timeout.
module regfile_access_sequencer
    import gpp_regctl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic             mem_data_valid,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             reg_write_x,
    output logic             reg_write_y,
    output logic             reg_write_accumulator,
    output logic             signal_save_after_alu,
    output logic             reg_read_x,
    output logic             reg_read_y,
    output logic             busy,
    output logic             err_timeout
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_next;
    regctl_cmd_t     r_cmd;
    regctl_cmd_t     w_cmd_next;
    regctl_cmd_t     w_cmd_in;

    logic w_accept;
    logic w_in_wait;
    logic w_ctr_clear;
    logic w_expired;
    logic w_timeout;
    logic w_rd_hold;

    logic w_wr_x, w_wr_y, w_wr_acc, w_save, w_rd_x, w_rd_y, w_alu_start;
    logic r_wr_x, r_wr_y, r_wr_acc, r_save, r_rd_x, r_rd_y, r_alu_start;
    logic r_ready, r_busy, r_err;

    assign w_cmd_in.op  = cmd_op;
    assign w_cmd_in.sel = cmd_sel;
    assign w_accept     = cmd_valid & r_ready;
    assign w_in_wait    = (r_state == ST_WAIT_MEM) || (r_state == ST_WAIT_ALU);
    assign w_ctr_clear  = ~w_in_wait;

    regctl_timeout_ctr #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_timeout_ctr (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_clear     (w_ctr_clear),
        .i_enable    (w_in_wait),
        .o_expired_c (w_expired)
    );

    // Next state, then strobes decoded from next state so they register in step with it.
    always_comb begin
        w_state_next = r_state;
        w_cmd_next   = r_cmd;
        w_timeout    = 1'b0;
        w_rd_hold    = 1'b0;
        w_wr_x       = 1'b0;
        w_wr_y       = 1'b0;
        w_wr_acc     = 1'b0;
        w_save       = 1'b0;
        w_rd_x       = 1'b0;
        w_rd_y       = 1'b0;
        w_alu_start  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cmd_next = w_cmd_in;
                    if (cmd_is_legal(w_cmd_in)) begin
                        case (cmd_op)
                            OP_LOAD: w_state_next = ST_WAIT_MEM;
                            OP_READ: w_state_next = ST_READ;
                            OP_ALU:  w_state_next = ST_OPND;
                            default: w_state_next = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_WAIT_MEM: begin
                // Data arriving on the expiring cycle still completes the load.
                if (mem_data_valid) begin
                    w_state_next = ST_WRITE;
                end else if (w_expired) begin
                    w_state_next = ST_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            ST_WAIT_ALU: begin
                if (alu_done) begin
                    w_state_next = ST_SAVE;
                end else if (w_expired) begin
                    w_state_next = ST_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            ST_OPND:  w_state_next = ST_WAIT_ALU;
            ST_WRITE: w_state_next = ST_IDLE;
            ST_READ:  w_state_next = ST_IDLE;
            ST_SAVE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase

        w_rd_hold   = (w_state_next == ST_READ) || (w_state_next == ST_OPND) ||
                      (w_state_next == ST_WAIT_ALU);
        w_rd_x      = w_rd_hold && (w_cmd_next.sel == SEL_X);
        w_rd_y      = w_rd_hold && (w_cmd_next.sel == SEL_Y);
        w_wr_x      = (w_state_next == ST_WRITE) && (w_cmd_next.sel == SEL_X);
        w_wr_y      = (w_state_next == ST_WRITE) && (w_cmd_next.sel == SEL_Y);
        w_wr_acc    = (w_state_next == ST_WRITE) && (w_cmd_next.sel == SEL_ACC);
        w_save      = (w_state_next == ST_SAVE);
        w_alu_start = (w_state_next == ST_OPND);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_wr_x      <= 1'b0;
            r_wr_y      <= 1'b0;
            r_wr_acc    <= 1'b0;
            r_save      <= 1'b0;
            r_rd_x      <= 1'b0;
            r_rd_y      <= 1'b0;
            r_alu_start <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmd       <= w_cmd_next;
            r_ready     <= (w_state_next == ST_IDLE);
            r_busy      <= (w_state_next != ST_IDLE);
            r_err       <= r_err | w_timeout;
            r_wr_x      <= w_wr_x;
            r_wr_y      <= w_wr_y;
            r_wr_acc    <= w_wr_acc;
            r_save      <= w_save;
            r_rd_x      <= w_rd_x;
            r_rd_y      <= w_rd_y;
            r_alu_start <= w_alu_start;
        end
    end

    assign cmd_ready             = r_ready;
    assign busy                  = r_busy;
    assign err_timeout           = r_err;
    assign reg_write_x           = r_wr_x;
    assign reg_write_y           = r_wr_y;
    assign reg_write_accumulator = r_wr_acc;
    assign signal_save_after_alu = r_save;
    assign reg_read_x            = r_rd_x;
    assign reg_read_y            = r_rd_y;
    assign alu_start             = r_alu_start;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Scoreboard bench: a command-level model predicts strobe events and latencies,
// a negedge monitor turns DUT outputs into events and compares them in order.
module tb_regfile_access_sequencer;

    localparam int TMO = 16;
    localparam int EV_WRITE = 1, EV_SAVE = 2, EV_ASTART = 3, EV_RSEL = 4, EV_END = 5;

    typedef struct packed {
        logic [3:0]  kind;
        logic [1:0]  sel;
        logic [31:0] cyc;
        logic [7:0]  len;
        logic        err;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] cmd_sel = 2'b00;
    logic mem_data_valid = 1'b0;
    logic alu_start;
    logic alu_done = 1'b0;
    logic reg_write_x, reg_write_y, reg_write_accumulator, signal_save_after_alu;
    logic reg_read_x, reg_read_y, busy, err_timeout;

    logic [15:0] data_in_mem = '0;
    logic [15:0] data_in_acc_alu = '0;
    logic [15:0] rf_x = '0, rf_y = '0, rf_acc = '0;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic exp_err = 1'b0;
    logic [15:0] exp_rf [3];
    ev_t  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_access_sequencer #(.WAIT_TIMEOUT(16), .CNT_W(5)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_op                (cmd_op),
        .cmd_sel               (cmd_sel),
        .mem_data_valid        (mem_data_valid),
        .alu_start             (alu_start),
        .alu_done              (alu_done),
        .reg_write_x           (reg_write_x),
        .reg_write_y           (reg_write_y),
        .reg_write_accumulator (reg_write_accumulator),
        .signal_save_after_alu (signal_save_after_alu),
        .reg_read_x            (reg_read_x),
        .reg_read_y            (reg_read_y),
        .busy                  (busy),
        .err_timeout           (err_timeout)
    );

    // Environment register file driven by the DUT strobes.
    always @(posedge clk) begin
        if (reg_write_x)           rf_x   <= data_in_mem;
        if (reg_write_y)           rf_y   <= data_in_mem;
        if (reg_write_accumulator) rf_acc <= data_in_mem;
        if (signal_save_after_alu) rf_acc <= data_in_acc_alu;
    end

    function automatic ev_t mk(input int kind, input int sel, input int c, input int len, input logic err);
        ev_t e;
        e.kind = 4'(kind);
        e.sel  = 2'(sel);
        e.cyc  = 32'(c);
        e.len  = 8'(len);
        e.err  = err;
        return e;
    endfunction

    function automatic bit legal_cmd(input int op, input int sel);
        return (op == 0 && sel <= 2) || ((op == 1 || op == 2) && sel <= 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic got_ev(input ev_t g);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d sel %0d cyc %0d len %0d err %0d, expected none",
                     g.kind, g.sel, g.cyc, g.len, g.err);
        end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
                n_fail++;
                $display("FAIL event: got kind %0d sel %0d cyc %0d len %0d err %0d, expected kind %0d sel %0d cyc %0d len %0d err %0d",
                         g.kind, g.sel, g.cyc, g.len, g.err, e.kind, e.sel, e.cyc, e.len, e.err);
            end
        end
    endtask

    // Command-level reference: a = first cycle after the accept edge, d = wait cycles before data/done.
    task automatic model_cmd(input int op, input int sel, input int a, input int d, input logic [15:0] data);
        if (!legal_cmd(op, sel)) return;
        case (op)
            0: begin
                if (d < TMO) begin
                    exp_q.push_back(mk(EV_WRITE, sel, a + 1 + d, 0, 1'b0));
                    exp_q.push_back(mk(EV_END, 0, a + d + 2, 0, exp_err));
                    exp_rf[sel] = data;
                end else begin
                    exp_err = 1'b1;
                    exp_q.push_back(mk(EV_END, 0, a + TMO, 0, 1'b1));
                end
            end
            1: begin
                exp_q.push_back(mk(EV_RSEL, sel, a, 1, 1'b0));
                exp_q.push_back(mk(EV_END, 0, a + 1, 0, exp_err));
            end
            default: begin
                exp_q.push_back(mk(EV_ASTART, sel, a, 0, 1'b0));
                if (d < TMO) begin
                    exp_q.push_back(mk(EV_SAVE, 0, a + d + 2, 0, 1'b0));
                    exp_q.push_back(mk(EV_RSEL, sel, a, d + 2, 1'b0));
                    exp_q.push_back(mk(EV_END, 0, a + d + 3, 0, exp_err));
                    exp_rf[2] = data;
                end else begin
                    exp_q.push_back(mk(EV_RSEL, sel, a, TMO + 1, 1'b0));
                    exp_err = 1'b1;
                    exp_q.push_back(mk(EV_END, 0, a + TMO + 1, 0, 1'b1));
                end
            end
        endcase
    endtask

    // Monitor: converts output activity into events and checks exclusivity every cycle.
    logic prev_busy = 1'b0;
    logic prev_rd = 1'b0;
    int   rd_start = 0;
    int   rd_sel = 0;
    always @(negedge clk) begin : mon
        int   nw;
        logic cur_rd;
        if (!rst) begin
            prev_busy = 1'b0;
            prev_rd   = 1'b0;
        end else begin
            nw = int'(reg_write_x) + int'(reg_write_y) + int'(reg_write_accumulator);
            chk("multi_write", int'(nw > 1), 0);
            chk("dual_read", int'(reg_read_x & reg_read_y), 0);
            chk("acc_conflict", int'(reg_write_accumulator & signal_save_after_alu), 0);
            if (nw > 0)
                got_ev(mk(EV_WRITE, reg_write_x ? 0 : (reg_write_y ? 1 : 2), cyc, 0, 1'b0));
            if (signal_save_after_alu)
                got_ev(mk(EV_SAVE, 0, cyc, 0, 1'b0));
            if (alu_start)
                got_ev(mk(EV_ASTART, reg_read_x ? 0 : (reg_read_y ? 1 : 3), cyc, 0, 1'b0));
            cur_rd = reg_read_x | reg_read_y;
            if (prev_rd && !cur_rd)
                got_ev(mk(EV_RSEL, rd_sel, rd_start, cyc - rd_start, 1'b0));
            if (cur_rd && !prev_rd) begin
                rd_start = cyc;
                rd_sel   = reg_read_x ? 0 : 1;
            end
            if (prev_busy && !busy)
                got_ev(mk(EV_END, 0, cyc, 0, err_timeout));
            prev_rd   = cur_rd;
            prev_busy = busy;
        end
    end

    task automatic send_cmd(input int op, input int sel, input bit hold, output int a);
        int n;
        n = 0;
        a = -1;
        cmd_op    = 2'(op);
        cmd_sel   = 2'(sel);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_wait", int'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        a = cyc;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int op, input int d);
        int n;
        n = 0;
        if (op == 0 && d > 0 && d < TMO) begin
            repeat (d) begin @(posedge clk); #1; end
            mem_data_valid = 1'b1;
        end
        if (op == 2 && d < TMO) begin
            repeat (d + 1) begin @(posedge clk); #1; end
            alu_done = 1'b1;
            @(posedge clk); #1;
            alu_done = 1'b0;
        end
        while (busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_release", int'(busy), 0);
        mem_data_valid = 1'b0;
        alu_done       = 1'b0;
    endtask

    task automatic do_cmd(input int op, input int sel, input int d, input logic [15:0] data, input bit hold);
        int a;
        int op_eff;
        op_eff          = legal_cmd(op, sel) ? op : 3;
        data_in_mem     = data;
        data_in_acc_alu = data;
        mem_data_valid  = (op_eff == 0) ? (d == 0) : 1'($urandom_range(0, 1));
        alu_done        = (op_eff == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        send_cmd(op, sel, hold, a);
        if (a < 0) return;
        model_cmd(op, sel, a, d, data);
        if (op_eff == 3) begin
            chk("ignored_busy", int'(busy), 0);
            chk("ignored_ready", int'(cmd_ready), 1);
        end
        finish_cmd(op_eff, d);
        chk("rf_x", int'(rf_x), int'(exp_rf[0]));
        chk("rf_y", int'(rf_y), int'(exp_rf[1]));
        chk("rf_acc", int'(rf_acc), int'(exp_rf[2]));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, int'(cmd_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err_timeout), 0);
        chk({tag, "_strobes"}, int'({reg_write_x, reg_write_y, reg_write_accumulator,
                                     signal_save_after_alu, reg_read_x, reg_read_y, alu_start}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a;
        int op, sel, d, r;
        foreach (exp_rf[i]) exp_rf[i] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk_reset_state("por");

        do_cmd(0, 0, 0, 16'hA5A5, 1'b0);
        chk("load_x_value", int'(rf_x), 16'hA5A5);

        do_cmd(2, 1, 2, 16'h1234, 1'b0);
        chk("alu_acc_value", int'(rf_acc), 16'h1234);

        do_cmd(0, 1, 15, 16'h5A5A, 1'b0);
        chk("boundary_err", int'(err_timeout), 0);
        chk("boundary_value", int'(rf_y), 16'h5A5A);

        do_cmd(0, 2, 16, 16'hDEAD, 1'b0);
        chk("timeout_err", int'(err_timeout), 1);

        do_cmd(1, 0, 0, 16'h0001, 1'b1);
        do_cmd(1, 1, 0, 16'h0002, 1'b1);
        do_cmd(3, 0, 0, 16'h0003, 1'b0);
        chk("sticky_err", int'(err_timeout), 1);

        for (int i = 0; i < 120; i++) begin
            op  = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 3));
            r   = int'($urandom_range(0, 9));
            d   = (r == 0) ? int'($urandom_range(16, 18)) : int'($urandom_range(0, 15));
            do_cmd(op, sel, d, 16'($urandom), 1'b0);
        end

        // Reset in the middle of WAIT_ALU: nothing further may be written.
        data_in_acc_alu = 16'hBEEF;
        mem_data_valid  = 1'b1;
        send_cmd(2, 1, 1'b0, a);
        if (a >= 0) begin
            model_cmd(2, 1, a, 20, 16'hBEEF);
            repeat (2) begin @(posedge clk); #1; end
            rst = 1'b0;
            exp_q.delete();
            repeat (2) begin @(posedge clk); #1; end
            rst = 1'b1;
            exp_err = 1'b0;
            mem_data_valid = 1'b0;
            chk_reset_state("midrst");
            chk("midrst_acc_kept", int'(rf_acc), int'(exp_rf[2]));
        end

        for (int i = 0; i < 20; i++) begin
            op  = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 3));
            d   = int'($urandom_range(0, 15));
            do_cmd(op, sel, d, 16'($urandom), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("leftover_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
